// File: rtl/exp_accel_core_if.sv
// Avalon-MM slave bus bundle for the exponent accelerator.
// Master side drives the strobes, slave side returns readdata.
interface exp_accel_core_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/exp_accel_core.sv
// BASE^EXP accelerator, left-to-right square-and-multiply.
// Fixed 2*EXP_W+2 cycle latency from start write to result.
module exp_accel_core #(
  parameter int EXP_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  exp_accel_core_if.slave   avs,
  output logic [31:0]       result_export,
  output logic              busy_export
);

  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SQ,
    S_MUL,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      base_r;
  logic [EXP_W-1:0] exp_r;
  logic [31:0]      base_sh;
  logic [EXP_W-1:0] exp_sh;
  logic [31:0]      acc;
  logic [IW-1:0]    idx;
  logic             ovf_work;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [31:0]      result;
  logic [31:0]      rd_mux;

  logic start_req;
  logic do_start;
  logic do_load;
  logic do_sq;
  logic do_mul;
  logic do_fin;
  logic mul_en;
  logic last_bit;

  logic [31:0] op_b;
  logic [63:0] prod;

  assign start_req = avs.avs_write
                   && (avs.avs_address == 3'd2)
                   && avs.avs_writedata[0];

  assign last_bit = (idx == '0);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start_req) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_SQ;
      S_SQ:   state_nxt = S_MUL;
      S_MUL:  state_nxt = last_bit ? S_FIN : S_SQ;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // per-state control strobes
  always_comb begin
    do_start = 1'b0;
    do_load  = 1'b0;
    do_sq    = 1'b0;
    do_mul   = 1'b0;
    do_fin   = 1'b0;
    unique case (state)
      S_IDLE: do_start = start_req;
      S_LOAD: do_load  = 1'b1;
      S_SQ:   do_sq    = 1'b1;
      S_MUL:  do_mul   = 1'b1;
      S_FIN:  do_fin   = 1'b1;
      default: ;
    endcase
  end

  // one shared multiplier: acc*acc when squaring, acc*base otherwise
  assign op_b   = do_sq ? acc : base_sh;
  assign prod   = {32'd0, acc} * {32'd0, op_b};
  assign mul_en = do_sq | (do_mul & exp_sh[idx]);

  // bus-visible operand registers, writable at any time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_r <= '0;
      exp_r  <= '0;
    end else if (avs.avs_write) begin
      if (avs.avs_address == 3'd0) base_r <= avs.avs_writedata;
      if (avs.avs_address == 3'd1) exp_r  <= avs.avs_writedata[EXP_W-1:0];
    end
  end

  // computation datapath working on shadow copies
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_sh  <= '0;
      exp_sh   <= '0;
      acc      <= '0;
      idx      <= '0;
      ovf_work <= 1'b0;
    end else if (do_load) begin
      base_sh  <= base_r;
      exp_sh   <= exp_r;
      acc      <= 32'd1;
      idx      <= IW'(EXP_W - 1);
      ovf_work <= 1'b0;
    end else begin
      if (mul_en) begin
        acc <= prod[31:0];
        if (prod[63:32] != 32'd0) ovf_work <= 1'b1;
      end
      if (do_mul && !last_bit) idx <= idx - 1'b1;
    end
  end

  // status flags and published result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
    end else begin
      if (do_start) begin
        done <= 1'b0;
        ovf  <= 1'b0;
      end
      if (do_load) busy <= 1'b1;
      if (do_fin) begin
        result <= acc;
        ovf    <= ovf_work;
        done   <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

  // read mux over pre-edge register contents
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (avs.avs_address == 3'd0): rd_mux = base_r;
      (avs.avs_address == 3'd1): rd_mux = 32'(exp_r);
      (avs.avs_address == 3'd3): rd_mux = {29'd0, ovf, done, busy};
      (avs.avs_address == 3'd4): rd_mux = result;
      default: rd_mux = '0;
    endcase
  end

  // registered read data, one cycle latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          avs.avs_readdata <= '0;
    else if (avs.avs_read) avs.avs_readdata <= rd_mux;
  end

  assign result_export = result;
  assign busy_export   = busy;

endmodule

// File: tb/tb_exp_accel_core.sv
// Directed bench for exp_accel_core.
// Hand-computed powers, latency and boundary checks.
module tb_exp_accel_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] result_export;
  logic        busy_export;
  int          cyc = 0;
  int          t0 = 0;
  int          vectors = 0;
  int          miscompares = 0;

  exp_accel_core_if bus ();

  exp_accel_core #(.EXP_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs           (bus),
    .result_export (result_export),
    .busy_export   (busy_export)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    tick();
    bus.avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    tick();
    bus.avs_read    = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic wait_fin(input string tag);
    int n;
    n = 0;
    while (busy_export && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(cyc - t0), 32'd66);
  endtask

  task automatic run(input string tag,
                     input logic [31:0] b,
                     input logic [31:0] e,
                     input logic [31:0] want,
                     input logic ov);
    logic [31:0] d;
    logic [31:0] prev;
    wr(3'd0, b);
    wr(3'd1, e);
    prev = result_export;
    wr(3'd2, 32'd1);
    t0 = cyc;
    check({tag, "_busy_t0"}, 32'(busy_export), 32'd0);
    tick();
    check({tag, "_busy_t1"}, 32'(busy_export), 32'd1);
    check({tag, "_hold"}, result_export, prev);
    wait_fin(tag);
    rd(3'd3, d);
    check({tag, "_status"}, d, {29'd0, ov, 2'b10});
    rd(3'd4, d);
    check({tag, "_result"}, d, want);
    check({tag, "_export"}, result_export, want);
  endtask

  initial begin
    logic [31:0] d;
    bus.avs_address   = '0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    repeat (3) tick();
    check("rst_rdata", bus.avs_readdata, 32'd0);
    check("rst_rexp", result_export, 32'd0);
    check("rst_bexp", 32'(busy_export), 32'd0);
    reset_n = 1'b1;
    tick();
    rd(3'd3, d); check("rst_status", d, 32'd0);
    rd(3'd4, d); check("rst_result", d, 32'd0);
    rd(3'd0, d); check("rst_base", d, 32'd0);
    rd(3'd1, d); check("rst_exp", d, 32'd0);

    run("p3_4", 32'd3, 32'd4, 32'd81, 1'b0);
    run("p2_31", 32'd2, 32'd31, 32'h8000_0000, 1'b0);
    run("p2_32", 32'd2, 32'd32, 32'd0, 1'b1);
    run("p0_0", 32'd0, 32'd0, 32'd1, 1'b0);
    run("p0_5", 32'd0, 32'd5, 32'd0, 1'b0);
    run("pff_0", 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0);

    // operand writes and restart attempt while busy
    wr(3'd0, 32'd5);
    wr(3'd1, 32'd3);
    wr(3'd2, 32'd1);
    t0 = cyc;
    repeat (8) tick();
    wr(3'd0, 32'd7);
    wr(3'd1, 32'd2);
    wr(3'd2, 32'd1);
    rd(3'd3, d); check("busy_status", d, 32'd1);
    check("busy_hold", result_export, 32'd1);
    wait_fin("busy");
    rd(3'd4, d); check("busy_result", d, 32'd125);
    rd(3'd0, d); check("busy_base", d, 32'd7);
    rd(3'd1, d); check("busy_exp", d, 32'd2);
    wr(3'd2, 32'd1);
    t0 = cyc;
    tick();
    wait_fin("rerun");
    rd(3'd4, d); check("rerun_result", d, 32'd49);
    rd(3'd3, d); check("rerun_status", d, 32'd2);

    // asynchronous abort mid-run
    wr(3'd0, 32'd10);
    wr(3'd1, 32'd9);
    wr(3'd2, 32'd1);
    t0 = cyc;
    while (cyc - t0 < 20) tick();
    reset_n = 1'b0;
    #1;
    check("abort_rexp", result_export, 32'd0);
    check("abort_bexp", 32'(busy_export), 32'd0);
    check("abort_rdata", bus.avs_readdata, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    rd(3'd3, d); check("abort_status", d, 32'd0);
    rd(3'd4, d); check("abort_result", d, 32'd0);
    rd(3'd0, d); check("abort_base", d, 32'd0);
    run("p10_9", 32'd10, 32'd9, 32'd1_000_000_000, 1'b0);

    // unmapped and write-only addresses
    wr(3'd5, 32'hDEAD_BEEF);
    rd(3'd5, d); check("addr5", d, 32'd0);
    rd(3'd6, d); check("addr6", d, 32'd0);
    rd(3'd7, d); check("addr7", d, 32'd0);
    rd(3'd2, d); check("ctrl_rd", d, 32'd0);

    // simultaneous read and write returns the old value
    bus.avs_address   = 3'd0;
    bus.avs_writedata = 32'h1234_5678;
    bus.avs_write     = 1'b1;
    bus.avs_read      = 1'b1;
    tick();
    bus.avs_write = 1'b0;
    bus.avs_read  = 1'b0;
    check("rw_old", bus.avs_readdata, 32'd10);
    rd(3'd0, d); check("rw_new", d, 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exp_accel_core.md
# exp_accel_core

- Avalon-MM slave component inside the exponent accelerator system. Computes BASE^EXP (unsigned, 32-bit) by left-to-right square-and-multiply.
- The processor programs operands, starts the run and polls status over the bus.
- The final result is also driven continuously onto a conduit that feeds the system's 32-bit readdata export, the path the HEX/LED display logic consumes.

## Interface
- EXP_W, 32: exponent width in bits; fixes iteration count.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  3  word address: 0 BASE, 1 EXP, 2 CTRL, 3 STATUS, 4 RESULT.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, fixed read latency 1.
- result_export  out  32  conduit; mirrors the RESULT register.
- busy_export  out  1  conduit; high while computing.
- One clock, `clk`. Reset is `reset_n`, asynchronous assert, active-low.

## Operation
- Registers:
  - BASE (R/W, 32 b).
  - EXP (R/W, low EXP_W bits used, upper bits read 0).
  - CTRL (W): bit0 = start; reads 0.
  - STATUS (R): bit0 busy, bit1 done, bit2 ovf.
  - RESULT (R): last completed result.
  - Addresses 5–7 read 0, writes ignored.
- States:
  - IDLE: waits for a start.
  - LOAD: latches the BASE/EXP shadows, sets acc=1, bit index i=EXP_W-1, clears ovf_work.
  - SQ: acc = acc*acc.
  - MUL: if exp_shadow[i], acc = acc*base_shadow, else hold. Then i-1, or FIN if i==0.
  - FIN: RESULT=acc, ovf=ovf_work, done=1, busy=0, then back to IDLE.
- Transitions: IDLE -> LOAD on a CTRL write with bit0=1; LOAD -> SQ; SQ -> MUL; MUL -> SQ, or FIN when i==0; FIN -> IDLE.
- Arithmetic:
  - Full 32x32 -> 64 product; acc takes the low 32 bits.
  - ovf_work is sticky: set when the upper 32 bits of any SQ or MUL product are non-zero.
  - Left-to-right order makes ovf exact, i.e. set iff the true BASE^EXP >= 2^32 (intermediates never exceed the final value for BASE>=2).
  - RESULT always equals BASE^EXP mod 2^32.
- Boundary rules:
  - 0^0 = 1. 0^n = 0 for n>0. x^0 = 1.
  - Start while busy: ignored; no restart, no state change.
  - BASE/EXP writes while busy: registers update, but the running computation uses its shadows. A new value takes effect on the next start.
  - done clears on an accepted start. It stays set through RESULT/STATUS reads.
  - RESULT and result_export hold the previous value until FIN. They are never exposed mid-computation.
  - Simultaneous read and write, or read during FIN: read returns the pre-edge register contents.
  - reset_n low mid-run: immediate abort to IDLE, all state cleared.
- Reset values: BASE 0, EXP 0, RESULT 0, busy 0, done 0, ovf 0, avs_readdata 0, result_export 0, busy_export 0, FSM IDLE.

## Timing
- Start write accepted at edge T0. LOAD at T1, busy=1 from T1.
- Each exponent bit takes 2 cycles (SQ, MUL), independent of bit value or leading zeros.
- FIN at T1+2*EXP_W+1. Done/RESULT are visible at edge T0+2*EXP_W+2 (66 cycles for EXP_W=32).
- Latency is deterministic and data-independent.
- avs_readdata is registered: valid on the cycle after avs_read. No waitrequest.
- result_export and busy_export are register outputs with no combinational path from the bus.
- Only one multiplier is active per cycle; a registered 64-bit product feeding acc is permitted as long as the latency above is preserved exactly.

## Test plan
- BASE=3, EXP=4, start -> busy=1 at T1. RESULT=81, done=1, ovf=0 at T0+66. result_export=81.
- BASE=2, EXP=31 -> RESULT=0x80000000, ovf=0. BASE=2, EXP=32 -> RESULT=0, ovf=1.
- BASE=0, EXP=0 -> RESULT=1. BASE=0, EXP=5 -> 0. BASE=0xFFFFFFFF, EXP=0 -> 1. All with ovf=0.
- Start BASE=5, EXP=3. At T0+10 write BASE=7, EXP=2 and a second start -> RESULT=125 at T0+66, no restart. Then start again -> RESULT=49.
- Start BASE=10, EXP=9. Assert reset_n low at T0+20 -> all outputs 0 immediately, STATUS=0. After release, a fresh run 10^9 -> RESULT=1000000000, ovf=0.
- Read addresses 5–7 and the upper EXP bits (when EXP_W<32) -> 0. A STATUS read during a run -> 0x1. After completion -> 0x2, or 0x6 with ovf set.
